// File: rtl/steg_pkg.sv
// Constants shared by the encode-side secret FIFO and the decode-side nibble packer.
package steg_pkg;
  localparam int DATA_WIDTH       = 32;
  localparam int MESS_WIDTH       = 4;
  localparam int NIBBLES_PER_WORD = DATA_WIDTH / MESS_WIDTH;
endpackage

// File: rtl/nibble_packer.sv
// Shifts nibbles MSB-first into a word; emits a push strobe on word completion or
// on a flush, left-aligning a partial word with zero padding.
module nibble_packer #(
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [MW-1:0] din_i,
  input  logic          wr_acc_i,
  input  logic          flush_i,
  input  logic          fifo_full_i,
  output logic [DW-1:0] word_o,
  output logic          push_o,
  output logic          last_o,
  output logic          partial_o
);
  localparam int N  = DW / MW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shreg_q, shreg_d, shifted;
  logic          complete, flush_en;
  int            k;

  assign last_o    = (cnt_q == CW'(N - 1));
  assign partial_o = (cnt_q != '0);
  assign complete  = wr_acc_i & last_o;
  // a nibble completing the word this cycle makes the flush redundant
  assign flush_en  = flush_i & ~fifo_full_i & partial_o & ~complete;

  always_comb begin
    shifted = wr_acc_i ? {shreg_q[DW-MW-1:0], din_i} : shreg_q;
    k       = int'(cnt_q) + (wr_acc_i ? 1 : 0);
    cnt_d   = wr_acc_i ? cnt_q + CW'(1) : cnt_q;
    shreg_d = shifted;
    word_o  = shifted;
    push_o  = 1'b0;
    if (complete) begin
      push_o  = 1'b1;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (flush_en) begin
      push_o  = 1'b1;
      word_o  = shifted << ((N - k) * MW);
      cnt_d   = '0;
      shreg_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end
endmodule

// File: rtl/secret_nibble_packer.sv
// Decode-side secret message buffer: packs recovered nibbles into words and queues
// them in a small FIFO with registered read data.
module secret_nibble_packer
  import steg_pkg::*;
#(
  parameter int DATA_WIDTH = steg_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 3,
  parameter int MESS_WIDTH = steg_pkg::MESS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MESS_WIDTH-1:0] din,
  input  logic                  wr_req,
  input  logic                  flush,
  output logic                  full,
  output logic                  partial,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q, dout_d, word;
  logic                  dout_valid_q, push, last, fifo_full, wr_acc, rd_en;

  // flags come from registered pointers only, so a new word never falls through
  assign fifo_full = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = fifo_full & last;
  assign wr_acc    = wr_req & ~full;
  assign rd_en     = rd_req & ~empty;

  nibble_packer #(.DW(DATA_WIDTH), .MW(MESS_WIDTH)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .din_i       (din),
    .wr_acc_i    (wr_acc),
    .flush_i     (flush),
    .fifo_full_i (fifo_full),
    .word_o      (word),
    .push_o      (push),
    .last_o      (last),
    .partial_o   (partial)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q + (ADDR_WIDTH + 1)'(push);
    rd_ptr_d = rd_ptr_q + (ADDR_WIDTH + 1)'(rd_en);
    dout_d   = rd_en ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= word;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_secret_nibble_packer.sv
// Directed bench for secret_nibble_packer: packing, flush, full hold-off, wrap, reset.
module tb_secret_nibble_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  din = '0;
  logic        wr_req = 1'b0, flush = 1'b0, rd_req = 1'b0;
  logic        full, partial, dout_valid, empty;
  logic [31:0] dout;
  int          n_vec = 0, n_err = 0;
  logic [31:0] exp_q [$];

  secret_nibble_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .MESS_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_req(wr_req), .flush(flush), .full(full),
    .partial(partial), .rd_req(rd_req), .dout(dout), .dout_valid(dout_valid), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] nib(int w, int j);
    return 4'((w + j) & 15);
  endfunction

  function automatic logic [31:0] wordv(int w);
    logic [31:0] r = '0;
    for (int j = 0; j < 8; j++) r = {r[27:0], nib(w, j)};
    return r;
  endfunction

  task automatic write_word(int w);
    for (int j = 0; j < 8; j++) begin din = nib(w, j); wr_req = 1'b1; step(); end
    wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; step(); step(); rst = 1'b1;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b exp 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b exp 0", full); end
    n_vec++; if (partial !== 1'b0) begin n_err++; $display("FAIL rst_partial got %b exp 0", partial); end
    n_vec++; if (dout !== 32'h0) begin n_err++; $display("FAIL rst_dout got %h exp 0", dout); end
    rd_req = 1'b1; step(); rd_req = 1'b0;
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rd_empty_valid got %b exp 0", dout_valid); end
  endtask

  task automatic test_pack();
    for (int j = 1; j <= 8; j++) begin
      din = 4'(j); wr_req = 1'b1; step();
      if (j == 1) begin
        n_vec++; if (partial !== 1'b1) begin n_err++; $display("FAIL pack_partial got %b exp 1", partial); end
      end
    end
    wr_req = 1'b0;
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL pack_empty got %b exp 0", empty); end
    rd_req = 1'b1; step(); rd_req = 1'b0;
    n_vec++; if (dout !== 32'h12345678) begin n_err++; $display("FAIL pack_dout got %h exp 12345678", dout); end
    n_vec++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL pack_valid got %b exp 1", dout_valid); end
    step();
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL pack_valid_pulse got %b exp 0", dout_valid); end
    n_vec++; if (dout !== 32'h12345678) begin n_err++; $display("FAIL pack_dout_hold got %h exp 12345678", dout); end
  endtask

  task automatic test_flush();
    din = 4'hA; wr_req = 1'b1; step(); din = 4'hB; step(); din = 4'hC; step(); wr_req = 1'b0;
    n_vec++; if (partial !== 1'b1) begin n_err++; $display("FAIL flush_partial_pre got %b exp 1", partial); end
    flush = 1'b1; step(); flush = 1'b0;
    n_vec++; if (partial !== 1'b0) begin n_err++; $display("FAIL flush_partial_post got %b exp 0", partial); end
    rd_req = 1'b1; step(); rd_req = 1'b0;
    n_vec++; if (dout !== 32'hABC00000) begin n_err++; $display("FAIL flush_dout got %h exp abc00000", dout); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_single got %b exp 1", empty); end
  endtask

  task automatic test_full();
    for (int w = 0; w < 8; w++) write_word(w);
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL full_early got %b exp 0", full); end
    for (int j = 0; j < 7; j++) begin din = 4'(9 + j); wr_req = 1'b1; step(); end
    wr_req = 1'b0;
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL full_set got %b exp 1", full); end
    flush = 1'b1; step(); flush = 1'b0;
    n_vec++; if (partial !== 1'b1) begin n_err++; $display("FAIL full_flush_held got %b exp 1", partial); end
    din = 4'h5; wr_req = 1'b1; step(); wr_req = 1'b0;
    n_vec++; if (partial !== 1'b1) begin n_err++; $display("FAIL full_refuse got %b exp 1", partial); end
    rd_req = 1'b1; step(); rd_req = 1'b0;
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL full_clear got %b exp 0", full); end
    n_vec++; if (dout !== wordv(0)) begin n_err++; $display("FAIL full_rd0 got %h exp %h", dout, wordv(0)); end
    din = 4'h1; wr_req = 1'b1; step(); wr_req = 1'b0;
    n_vec++; if (partial !== 1'b0) begin n_err++; $display("FAIL full_complete got %b exp 0", partial); end
    rd_req = 1'b1;
    for (int w = 1; w < 8; w++) begin
      step();
      n_vec++; if (dout !== wordv(w)) begin n_err++; $display("FAIL full_order got %h exp %h", dout, wordv(w)); end
    end
    step(); rd_req = 1'b0;
    n_vec++; if (dout !== 32'h9ABCDEF1) begin n_err++; $display("FAIL full_last got %h exp 9abcdef1", dout); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL full_drained got %b exp 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    for (int w = 100; w < 104; w++) begin write_word(w); exp_q.push_back(wordv(w)); end
    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < 8; j++) begin
        din = nib(200 + it, j); wr_req = 1'b1; rd_req = (j == 7); step();
      end
      wr_req = 1'b0; rd_req = 1'b0;
      e = exp_q.pop_front(); exp_q.push_back(wordv(200 + it));
      n_vec++; if (dout !== e || dout_valid !== 1'b1) begin n_err++; $display("FAIL b2b_dout got %h/%b exp %h/1", dout, dout_valid, e); end
    end
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); e = exp_q.pop_front();
      n_vec++; if (dout !== e) begin n_err++; $display("FAIL b2b_drain got %h exp %h", dout, e); end
    end
    rd_req = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_count got empty=%b exp 1", empty); end
  endtask

  task automatic test_reset_mid();
    for (int w = 300; w < 303; w++) write_word(w);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    n_vec++; if (dout !== wordv(300)) begin n_err++; $display("FAIL mid_pre_dout got %h exp %h", dout, wordv(300)); end
    for (int j = 0; j < 5; j++) begin din = 4'(j); wr_req = 1'b1; step(); end
    wr_req = 1'b0;
    rst = 1'b0; step(); rst = 1'b1;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b exp 1", empty); end
    n_vec++; if (partial !== 1'b0) begin n_err++; $display("FAIL mid_partial got %b exp 0", partial); end
    n_vec++; if (dout !== 32'h0) begin n_err++; $display("FAIL mid_dout got %h exp 0", dout); end
    for (int j = 8; j >= 1; j--) begin din = 4'(j); wr_req = 1'b1; step(); end
    wr_req = 1'b0; rd_req = 1'b1; step(); rd_req = 1'b0;
    n_vec++; if (dout !== 32'h87654321) begin n_err++; $display("FAIL mid_clean got %h exp 87654321", dout); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_one_word got %b exp 1", empty); end
  endtask

  task automatic test_flush_last();
    for (int j = 1; j <= 7; j++) begin din = 4'(j); wr_req = 1'b1; step(); end
    din = 4'h8; flush = 1'b1; step(); wr_req = 1'b0;
    step(); flush = 1'b0;
    n_vec++; if (partial !== 1'b0) begin n_err++; $display("FAIL fl8_partial got %b exp 0", partial); end
    rd_req = 1'b1; step(); rd_req = 1'b0;
    n_vec++; if (dout !== 32'h12345678) begin n_err++; $display("FAIL fl8_dout got %h exp 12345678", dout); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fl8_no_extra got %b exp 1", empty); end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_flush();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_flush_last();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
